// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC owner, ROM fetch driver and small decode-side FIFO with redirect/flush.
// Optional macro FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection (misalign_o).
`default_nettype none

module inst_fetch_queue #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        misalign_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic [31:0]     inst_mem_q [FIFO_DEPTH];

  logic            redirect, pop, push, fetch_ok;
  logic [31:0]     target;

  assign redirect = flush_i || branch_flag_i;
  assign target   = flush_i ? new_pc_i : branch_target_i;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_ok   = !misalign_q;
  assign misalign_d = redirect ? (target[1:0] != 2'b00) : misalign_q;
`else
  assign fetch_ok   = 1'b1;
  assign misalign_d = 1'b0;
`endif

  assign id_valid_o = (count_q != '0);
  assign pop        = id_valid_o && id_ready_i;
  assign rom_ce_o   = (state_q == FETCH) && !redirect && fetch_ok &&
                      ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign push       = rom_ce_o;
  assign rom_addr_o = pc_q;
  assign misalign_o = misalign_q;
  assign id_pc_o    = id_valid_o ? pc_mem_q[rd_q]   : 32'h0;
  assign id_inst_o  = id_valid_o ? inst_mem_q[rd_q] : 32'h0;

  // A redirect discards the whole queue, so any same-cycle pop is irrelevant.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (redirect) begin
      pc_d    = target & ~32'h3;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= FETCH;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]   <= pc_q;
      inst_mem_q[wr_q] <= rom_inst_i;
    end
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch stage upstream of the combinational instruction ROM: owns the PC, drives the ROM chip-enable and address, and captures the returned words.
- Captured words go into a small FIFO that feeds decode through a valid/ready handshake.
- Decouples decode stalls from fetch; handles branch redirects and pipeline flushes by discarding queued words and restarting at a new PC.

Parameters:
- FIFO_DEPTH, 4, queue entries (power of two, 2..16).
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rom_ce_o  output  1  ROM chip-enable.
- rom_addr_o  output  32  ROM byte address (word-aligned).
- rom_inst_i  input  32  ROM data, valid same cycle as rom_addr_o.
- id_valid_o  output  1  head entry valid.
- id_ready_i  input  1  decode accepts head this cycle.
- id_pc_o  output  32  PC of head entry.
- id_inst_o  output  32  instruction of head entry; 32'h0 when not valid.
- branch_flag_i  input  1  redirect request from decode.
- branch_target_i  input  32  redirect target.
- flush_i  input  1  exception/flush request.
- new_pc_i  input  32  flush target (handler address).
- misalign_o  output  1  misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset, asynchronous:
  - pc = RESET_PC; FIFO count = 0; read and write pointers = 0; state = IDLE.
  - Outputs: rom_ce_o = 0, id_valid_o = 0, id_inst_o = 0, id_pc_o = 0, misalign_o = 0.
- State machine:
  - IDLE: entered only from reset; one cycle with rom_ce_o = 0; then FETCH.
  - FETCH: normal operation; stays in FETCH permanently until reset.
- Push, pop and ROM interface:
  - pop = id_valid_o && id_ready_i.
  - push = rom_ce_o.
  - rom_ce_o = (state == FETCH) && !redirect && (count < FIFO_DEPTH || pop).
  - rom_addr_o = pc, driven combinationally from the register; rom_addr_o[1:0] is always 0.
  - On push: FIFO[wr] <= {pc, rom_inst_i}; pc <= pc + 4 (32-bit wrap: 32'hFFFFFFFC -> 0).
- Simultaneous push and pop: count is unchanged. Push while full is legal only with a same-cycle pop.
- id_valid_o = (count != 0), registered-state derived. id_pc_o and id_inst_o come from FIFO[rd], zeroed when count == 0.
- Redirect:
  - redirect = flush_i || branch_flag_i; flush_i has priority and uses new_pc_i, otherwise branch_target_i.
  - In the redirect cycle: no push; a same-cycle pop is ignored.
  - At the clock edge: count = 0, both pointers = 0, pc <= target with bits [1:0] forced to 0.
  - Next cycle: id_valid_o = 0 and the fetch of the target is issued, so the first target word reaches decode 2 cycles after the redirect cycle.
- Back-to-back redirects: the latest one wins; each restarts the sequence.
- Latency:
  - An address issued in cycle N appears at the head in cycle N+1 if the queue was empty.
  - Steady-state throughput is 1 instr/cycle with id_ready_i held high.
- Reset asserted mid-operation: all state clears immediately; no partial entries survive.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - If the selected redirect target has [1:0] != 0, misalign_o is set to 1 at the redirect edge and held until the next redirect or reset.
  - While misalign_o = 1, rom_ce_o stays 0: no fetches, queue empty.
  - The flush/exception unit is expected to respond with flush_i to a handler address.
  - A subsequent aligned redirect clears misalign_o and resumes fetch.
- Undefined: misalign_o is tied to 0 and target bits [1:0] are silently dropped.

Test Plan:
- Reset then run with id_ready_i = 1 and ROM words = address/4:
  - cycle 0 after reset has rom_ce_o = 0.
  - Then rom_addr_o goes 0, 4, 8, …
  - Decode sees pc 0, 4, 8 with inst 0, 1, 2 on consecutive cycles, starting 2 cycles after reset release.
- Hold id_ready_i = 0: queue fills to 4 entries (pc 0..12) and rom_ce_o drops to 0. Raise id_ready_i for one cycle: pc 0 pops and pc 16 is fetched in the same cycle.
- branch_flag_i = 1 with target 32'h00000100 while the queue holds 3 entries: next cycle id_valid_o = 0 and rom_addr_o = 0x100; the following cycle id_pc_o = 0x100.
- flush_i = 1 with new_pc_i = 0x20, together with branch_flag_i = 1 and target 0x100: fetch resumes at 0x20.
- Wrap: redirect to 32'hFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- FETCH_ALIGN_CHECK_EN defined, branch to 0x102 → misalign_o = 1 and rom_ce_o stays 0. Then flush_i to 0x40 → misalign_o = 0 and fetch resumes at 0x40. Macro undefined: the same branch fetches 0x100.
